// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - UART register map, bridge FSM states and packet checksum
package uart_bridge_pkg;

    localparam logic [4:0] UART_RX_ADDR     = 5'h00;
    localparam logic [4:0] UART_TX_ADDR     = 5'h04;
    localparam logic [4:0] UART_STATUS_ADDR = 5'h08;
    localparam int         TX_OK_BIT        = 6;
    localparam int         RX_OK_BIT        = 7;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         RESYNC_POLL_W     = 20;

    typedef enum logic [1:0] {
        S_POLL,
        S_RX,
        S_TX,
        S_CHK
    } bridge_state_t;

    function automatic logic [7:0] pkt_checksum(input logic [7:0] id,
                                                input logic [7:0] data_hi,
                                                input logic [7:0] data_lo);
        return id ^ data_hi ^ data_lo;
    endfunction

endpackage

// File: rtl/uart_param_regfile.sv
// rtl/uart_param_regfile.sv - 16-bit parameter registers with one-cycle update pulses
module uart_param_regfile #(
    parameter int                        NUM_PARAMS = 4,
    parameter logic [NUM_PARAMS*16-1:0]  PARAM_RST  = '0
) (
    input  logic                    avm_clk,
    input  logic                    avm_rst,
    input  logic [7:0]              i_wr_id,
    input  logic [15:0]             i_wr_data,
    input  logic                    i_wr_valid,
    output logic [NUM_PARAMS*16-1:0] o_params,
    output logic [NUM_PARAMS-1:0]   o_param_upd
);

    logic [NUM_PARAMS*16-1:0] r_params;
    logic [NUM_PARAMS-1:0]    r_upd;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_params <= PARAM_RST;
            r_upd    <= '0;
        end else begin
            r_upd <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (i_wr_valid && (int'(i_wr_id) == i)) begin
                    r_params[i*16 +: 16] <= i_wr_data;
                    r_upd[i]             <= 1'b1;
                end
            end
        end
    end

    assign o_params    = r_params;
    assign o_param_upd = r_upd;

endmodule

// File: rtl/avm_uart_spectrum_bridge.sv
// rtl/avm_uart_spectrum_bridge.sv - Avalon-MM UART master: spectrum frames out, parameter packets in
module avm_uart_spectrum_bridge
    import uart_bridge_pkg::*;
#(
    parameter int                        NUM_BINS   = 16,
    parameter int                        BIN_W      = 16,
    parameter int                        NUM_PARAMS = 4,
    parameter logic [NUM_PARAMS*16-1:0]  PARAM_RST  = {16'd0, 16'd5, 16'd16383, 16'd0},
    parameter logic [7:0]                SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                          avm_clk,
    input  logic                          avm_rst,
    output logic [4:0]                    avm_address,
    output logic                          avm_read,
    input  logic [31:0]                   avm_readdata,
    output logic                          avm_write,
    output logic [31:0]                   avm_writedata,
    input  logic                          avm_waitrequest,
    input  logic [NUM_BINS*BIN_W-1:0]     freqs,
    input  logic                          tx_enable,
    output logic [NUM_PARAMS*16-1:0]      params,
    output logic [NUM_PARAMS-1:0]         param_upd,
    output logic [7:0]                    pkt_err_cnt
);

    localparam int SNAP_W    = NUM_BINS * BIN_W;
    localparam int FRAME_LEN = 1 + SNAP_W / 8;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    bridge_state_t            r_state;
    logic [4:0]               r_address;
    logic                     r_read;
    logic                     r_write;
    logic [31:0]              r_writedata;
    logic [31:0]              r_rx_buf;
    logic [1:0]               r_rx_cnt;
    logic [IDX_W-1:0]         r_tx_idx;
    logic [SNAP_W-1:0]        r_snap;
    logic [RESYNC_POLL_W-1:0] r_idle_polls;
    logic [7:0]               r_err_cnt;

    logic                     w_done;
    logic                     w_rx_ok;
    logic                     w_tx_ok;
    logic [IDX_W-1:0]         w_byte_sel;
    logic [7:0]               w_tx_byte;
    logic                     w_pkt_ok;
    logic                     w_unused;

    assign w_done  = !avm_waitrequest;
    assign w_rx_ok = avm_readdata[RX_OK_BIT];
    assign w_tx_ok = avm_readdata[TX_OK_BIT];
    assign w_unused = ^avm_readdata[31:8];

    // Index 0 is the sync byte; the selector is clamped so the snapshot slice stays in range.
    assign w_byte_sel = (r_tx_idx == '0) ? IDX_W'(1) : r_tx_idx;
    assign w_tx_byte  = (r_tx_idx == '0) ? SYNC_BYTE
                                         : r_snap[SNAP_W - 8*int'(w_byte_sel) +: 8];

    // Buffer holds {id, data_hi, data_lo, chk} once the fourth byte is in.
    assign w_pkt_ok = (pkt_checksum(r_rx_buf[31:24], r_rx_buf[23:16], r_rx_buf[15:8]) == r_rx_buf[7:0])
                   && (int'(r_rx_buf[31:24]) < NUM_PARAMS);

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_state      <= S_POLL;
            r_address    <= UART_STATUS_ADDR;
            r_read       <= 1'b1;
            r_write      <= 1'b0;
            r_writedata  <= '0;
            r_rx_buf     <= '0;
            r_rx_cnt     <= '0;
            r_tx_idx     <= '0;
            r_snap       <= '0;
            r_idle_polls <= '0;
            r_err_cnt    <= '0;
        end else begin
            case (r_state)
                S_POLL: begin
                    if (w_done) begin
                        if (w_rx_ok) begin
                            r_state      <= S_RX;
                            r_address    <= UART_RX_ADDR;
                            r_idle_polls <= '0;
                        end else begin
                            // A stalled partial packet is dropped so it cannot merge with the next one.
                            if (r_rx_cnt != '0) begin
                                if (&r_idle_polls) begin
                                    r_rx_cnt     <= '0;
                                    r_idle_polls <= '0;
                                end else begin
                                    r_idle_polls <= r_idle_polls + 1'b1;
                                end
                            end else begin
                                r_idle_polls <= '0;
                            end
                            if (w_tx_ok && ((r_tx_idx != '0) || tx_enable)) begin
                                r_state     <= S_TX;
                                r_read      <= 1'b0;
                                r_write     <= 1'b1;
                                r_address   <= UART_TX_ADDR;
                                r_writedata <= {24'h0, w_tx_byte};
                            end
                        end
                    end
                end
                S_RX: begin
                    if (w_done) begin
                        r_rx_buf <= {r_rx_buf[23:0], avm_readdata[7:0]};
                        if (r_rx_cnt == 2'd3) begin
                            r_rx_cnt <= '0;
                            r_state  <= S_CHK;
                            r_read   <= 1'b0;
                        end else begin
                            r_rx_cnt <= r_rx_cnt + 1'b1;
                            r_state  <= S_POLL;
                        end
                        r_address <= UART_STATUS_ADDR;
                    end
                end
                S_TX: begin
                    if (w_done) begin
                        if (r_tx_idx == '0)
                            r_snap <= freqs;
                        r_tx_idx  <= (r_tx_idx == IDX_W'(FRAME_LEN - 1)) ? '0 : r_tx_idx + 1'b1;
                        r_write   <= 1'b0;
                        r_read    <= 1'b1;
                        r_address <= UART_STATUS_ADDR;
                        r_state   <= S_POLL;
                    end
                end
                S_CHK: begin
                    if (!w_pkt_ok && (r_err_cnt != 8'hFF))
                        r_err_cnt <= r_err_cnt + 1'b1;
                    r_read  <= 1'b1;
                    r_state <= S_POLL;
                end
                default: begin
                    r_state <= S_POLL;
                end
            endcase
        end
    end

    uart_param_regfile #(
        .NUM_PARAMS (NUM_PARAMS),
        .PARAM_RST  (PARAM_RST)
    ) u_regfile (
        .avm_clk     (avm_clk),
        .avm_rst     (avm_rst),
        .i_wr_id     (r_rx_buf[31:24]),
        .i_wr_data   (r_rx_buf[23:8]),
        .i_wr_valid  ((r_state == S_CHK) && w_pkt_ok),
        .o_params    (params),
        .o_param_upd (param_upd)
    );

    assign avm_address   = r_address;
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = r_writedata;
    assign pkt_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_avm_uart_spectrum_bridge.sv
// tb/tb_avm_uart_spectrum_bridge.sv - randomized UART slave with behavioural frame/packet model
module tb_avm_uart_spectrum_bridge;

    localparam int          NP     = 4;
    localparam int          NBYTES = 32;
    localparam int          L      = 33;
    localparam logic [63:0] PRST   = {16'd0, 16'd5, 16'd16383, 16'd0};

    logic         avm_clk = 1'b0;
    logic         avm_rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic [255:0] freqs;
    logic         tx_enable;
    logic [63:0]  params;
    logic [3:0]   param_upd;
    logic [7:0]   pkt_err_cnt;

    avm_uart_spectrum_bridge dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .freqs           (freqs),
        .tx_enable       (tx_enable),
        .params          (params),
        .param_upd       (param_upd),
        .pkt_err_cnt     (pkt_err_cnt)
    );

    always #5 avm_clk = ~avm_clk;

    int checks = 0;
    int failures = 0;

    int cfg_wait_pct = 30;
    int cfg_rx_pct   = 100;
    int cfg_tx_pct   = 0;
    bit cfg_force_wait = 1'b0;

    logic [7:0]   rxq[$];
    logic [7:0]   txlog[$];

    logic [15:0]  m_params[NP];
    logic [7:0]   m_err;
    logic [7:0]   m_pkt[$];
    int           m_pos;
    logic [255:0] m_snap;
    int           pend_cnt;
    int           pend_id;
    logic [15:0]  pend_data;
    logic [3:0]   m_upd_exp;
    int           exp_next;
    bit           last_te;
    bit           prev_wait;
    logic [38:0]  prev_bus;
    int           upd_cnt;
    logic [3:0]   upd_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int bus_op();
        if (avm_read && !avm_write && avm_address == 5'h08) return 1;
        if (avm_read && !avm_write && avm_address == 5'h00) return 2;
        if (avm_write && !avm_read && avm_address == 5'h04) return 3;
        if (!avm_read && !avm_write) return 0;
        return 7;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [255:0] snap, input int k);
        logic [255:0] t;
        t = snap >> (8 * (NBYTES - k));
        return t[7:0];
    endfunction

    // UART slave, model update and per-cycle compare, all away from the rising edge.
    always @(negedge avm_clk) begin
        int op;
        bit wr, rxok, txok;
        logic [31:0] rnd;
        logic [7:0] b, eb;
        if (avm_rst) begin
            check("rst_read", avm_read, 1);
            check("rst_write", avm_write, 0);
            check("rst_addr", avm_address, 5'h08);
            check("rst_params", params, PRST);
            check("rst_upd", param_upd, 0);
            check("rst_err", pkt_err_cnt, 0);
            for (int i = 0; i < NP; i++) m_params[i] = PRST[i*16 +: 16];
            m_err = 0; m_pos = 0; pend_cnt = 0; m_upd_exp = 0;
            exp_next = -1; prev_wait = 0; last_te = 0;
            rxq.delete(); m_pkt.delete();
            avm_waitrequest = 1'b1;
            avm_readdata = '0;
        end else begin
            m_upd_exp = 0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    if (pend_id >= 0) begin
                        m_params[pend_id] = pend_data;
                        m_upd_exp[pend_id] = 1'b1;
                    end else if (m_err != 8'hFF) begin
                        m_err++;
                    end
                end
            end
            check("params", params, {m_params[3], m_params[2], m_params[1], m_params[0]});
            check("param_upd", param_upd, m_upd_exp);
            check("pkt_err_cnt", pkt_err_cnt, m_err);
            if (param_upd != 0) begin upd_cnt++; upd_last = param_upd; end

            op = bus_op();
            if (exp_next >= 0) check("bus_op", op, exp_next);
            if (prev_wait) check("bus_hold", {avm_read, avm_write, avm_address, avm_writedata}, prev_bus);

            wr = cfg_force_wait || ($urandom_range(99) < cfg_wait_pct);
            avm_waitrequest = wr;
            rnd = $urandom();
            rxok = (rxq.size() > 0) && ($urandom_range(99) < cfg_rx_pct);
            txok = ($urandom_range(99) < cfg_tx_pct);
            if (op == 1)
                avm_readdata = (rnd & 32'hFFFF_FF3F) | {24'h0, rxok, txok, 6'h0};
            else if (op == 2)
                avm_readdata = {rnd[31:8], (rxq.size() > 0) ? rxq[0] : 8'h00};
            else
                avm_readdata = rnd;

            if (op == 0) begin
                exp_next = 1;
            end else if (wr) begin
                exp_next = op;
            end else begin
                case (op)
                    1: begin
                        last_te = tx_enable;
                        if (rxok) exp_next = 2;
                        else if (txok && (m_pos != 0 || tx_enable)) exp_next = 3;
                        else exp_next = 1;
                    end
                    2: begin
                        b = rxq.pop_front();
                        m_pkt.push_back(b);
                        exp_next = 1;
                        if (m_pkt.size() == 4) begin
                            if ((m_pkt[3] == (m_pkt[0] ^ m_pkt[1] ^ m_pkt[2])) && (m_pkt[0] < NP)) begin
                                pend_id = int'(m_pkt[0]);
                                pend_data = {m_pkt[1], m_pkt[2]};
                            end else begin
                                pend_id = -1;
                            end
                            pend_cnt = 2;
                            m_pkt.delete();
                            exp_next = 0;
                        end
                    end
                    3: begin
                        if (m_pos == 0) begin
                            eb = 8'hA5;
                            check("frame_start_enabled", last_te, 1);
                            m_snap = freqs;
                        end else begin
                            eb = frame_byte(m_snap, m_pos);
                        end
                        check("tx_byte", avm_writedata, {24'h0, eb});
                        txlog.push_back(avm_writedata[7:0]);
                        m_pos = (m_pos + 1) % L;
                        exp_next = 1;
                    end
                    default: exp_next = -1;
                endcase
            end
            prev_wait = (op != 0) && wr;
            prev_bus  = {avm_read, avm_write, avm_address, avm_writedata};
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge avm_clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        @(posedge avm_clk); #2 avm_rst = 1'b1;
        step(n);
        avm_rst = 1'b0;
    endtask

    task automatic push_pkt(input logic [7:0] id, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk);
        rxq.push_back(id); rxq.push_back(hi); rxq.push_back(lo); rxq.push_back(chk);
    endtask

    task automatic wait_rx_idle(input int budget);
        int n = 0;
        while (!(rxq.size() == 0 && m_pkt.size() == 0 && pend_cnt == 0) && n < budget) begin step(1); n++; end
        check("rx_idle_timeout", n < budget, 1);
        step(3);
    endtask

    task automatic wait_txlog(input int cnt, input int budget);
        int n = 0;
        while (txlog.size() < cnt && n < budget) begin step(1); n++; end
        check("txlog_timeout", n < budget, 1);
    endtask

    task automatic wait_frame_end(input int budget);
        int n = 0;
        while (m_pos != 0 && n < budget) begin step(1); n++; end
        check("frame_end_timeout", n < budget, 1);
    endtask

    initial begin
        logic [7:0] acc;
        logic [7:0] id, hi, lo, ck;
        int n;
        avm_rst = 1'b1; avm_waitrequest = 1'b1; avm_readdata = '0;
        freqs = '0; tx_enable = 1'b0;
        upd_cnt = 0; upd_last = 0;
        step(3);
        avm_rst = 1'b0;

        cfg_force_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_read", avm_read, 1);
            check("stall_addr", avm_address, 5'h08);
            check("stall_params", params, PRST);
        end
        cfg_force_wait = 1'b0;

        cfg_tx_pct = 0; upd_cnt = 0;
        push_pkt(8'h01, 8'h12, 8'h34, 8'h27);
        wait_rx_idle(500);
        check("pkt1_param1", params[31:16], 16'h1234);
        check("pkt1_upd_pulses", upd_cnt, 1);
        check("pkt1_upd_value", upd_last, 4'b0010);

        push_pkt(8'h02, 8'h00, 8'h07, 8'h00);
        push_pkt(8'h09, 8'h00, 8'h00, 8'h09);
        wait_rx_idle(800);
        check("bad_pkt_err", pkt_err_cnt, 8'd2);
        check("bad_pkt_params", params, {16'd0, 16'd5, 16'h1234, 16'd0});

        freqs = 256'hABCD << 240;
        tx_enable = 1'b1; cfg_tx_pct = 100; txlog.delete();
        wait_txlog(1, 200);
        tx_enable = 1'b0;
        wait_txlog(5, 200);
        freqs = {8{$urandom()}};
        wait_txlog(L, 2000);
        wait_frame_end(200);
        step(50);
        check("frame_len", txlog.size(), L);
        check("frame_b0", txlog[0], 8'hA5);
        check("frame_b1", txlog[1], 8'hAB);
        check("frame_b2", txlog[2], 8'hCD);
        acc = 0;
        for (int i = 3; i < txlog.size(); i++) acc |= txlog[i];
        check("frame_tail_zero", acc, 8'h00);

        freqs = {8{$urandom()}};
        cfg_wait_pct = 20; cfg_rx_pct = 100; tx_enable = 1'b1; txlog.delete();
        wait_txlog(3, 200);
        push_pkt(8'h00, 8'h00, 8'h05, 8'h05);
        wait_rx_idle(800);
        tx_enable = 1'b0;
        wait_frame_end(2000);
        check("interleave_param0", params[15:0], 16'h0005);
        check("interleave_whole_frames", txlog.size() % L, 0);

        for (int it = 0; it < 40; it++) begin
            freqs = {8{$urandom()}};
            tx_enable = $urandom_range(1);
            cfg_wait_pct = $urandom_range(60);
            cfg_rx_pct = $urandom_range(100, 30);
            cfg_tx_pct = $urandom_range(100);
            id = 8'($urandom_range(5)); hi = 8'($urandom()); lo = 8'($urandom());
            ck = id ^ hi ^ lo;
            if ($urandom_range(3) == 0) ck = ck ^ 8'($urandom_range(255, 1));
            push_pkt(id, hi, lo, ck);
            step($urandom_range(200, 20));
        end
        cfg_rx_pct = 100; cfg_tx_pct = 100; tx_enable = 1'b0;
        wait_rx_idle(3000);
        wait_frame_end(3000);

        cfg_wait_pct = 20; tx_enable = 1'b1;
        n = 0;
        while (m_pos != 10 && n < 1000) begin step(1); n++; end
        check("reach_byte10", n < 1000, 1);
        do_reset(2);
        txlog.delete();
        wait_txlog(1, 300);
        check("post_reset_sync", txlog[0], 8'hA5);
        tx_enable = 1'b0;
        wait_frame_end(2000);

        cfg_tx_pct = 0;
        push_pkt(8'h03, 8'h11, 8'h22, 8'h30);
        n = 0;
        while (m_pkt.size() != 1 && n < 500) begin step(1); n++; end
        check("reach_rx_byte2", n < 500, 1);
        do_reset(2);
        push_pkt(8'h03, 8'hAB, 8'hCD, 8'h65);
        wait_rx_idle(500);
        check("post_reset_param3", params[63:48], 16'hABCD);
        check("post_reset_err", pkt_err_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
